// File: rtl/stopwatch_time_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared definitions for the stopwatch control FSM and its
//               time counter datapath. These are the select encodings on
//               T_s, the BCD digit width, the per-digit maximum and the
//               ceiling of the 4-digit count.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // T_s select encodings; 2'b11 is decoded as hold by the datapath
    localparam logic [1:0]  TS_INIT   = 2'b00;
    localparam logic [1:0]  TS_TICK   = 2'b01;
    localparam logic [1:0]  TS_HOLD   = 2'b10;

    localparam int          DIGIT_W   = 4;
    localparam int          NUM_DIGITS = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;
    localparam logic [15:0] BCD_MAX   = 16'h9999;

endpackage
`default_nettype wire

// File: rtl/stopwatch_time_counter_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One decimal (BCD) counter digit, 0..9.
//   clk  in  1 : clock, posedge
//   rst  in  1 : synchronous active-high reset (digit -> 0)
//   clr  in  1 : synchronous clear (digit -> 0), beats en
//   en   in  1 : carry-in; digit advances by one, wrapping 9 -> 0
//   q    out 4 : current digit value
//   co   out 1 : digit is at 9; the caller ANDs it with en to form the
//                carry into the next digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               co
);

    logic [DIGIT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q == DIGIT_MAX) ? '0 : r_q + 1'b1;
        end
    end

    assign q  = r_q;
    assign co = (r_q == DIGIT_MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_time_counter
// Description : Time base and 4-digit BCD counter (SS.hh, 00.00..99.99) of
//               the stopwatch. A prescaler divides clk down to the tick rate,
//               and a ripple chain of bcd_digit instances counts the ticks.
//               The count saturates at 99.99.
//   clk        in  1  : system clock
//   rst        in  1  : synchronous active-high reset
//   T_s        in  2  : 00 load zero, 01 count, 10/11 hold
//   T_ld       in  1  : update enable; 0 freezes all state
//   lap        in  1  : lap strobe (only with STOPWATCH_LAP_EN)
//   T_comp     out 1  : live count equals 99.99
//   time_bcd   out 16 : displayed time {d3,d2,d1,d0}
//   tick_pulse out 1  : registered pulse after each real increment
// Config macro: STOPWATCH_LAP_EN adds the lap port and the lap-freeze
//               display register.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  T_s,
    input  logic        T_ld,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
`endif
    output logic        T_comp,
    output logic [15:0] time_bcd,
    output logic        tick_pulse
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]      r_pre;
    logic                  r_tick;
    logic [15:0]           w_count;
    logic [NUM_DIGITS-1:0] w_nine;
    logic [NUM_DIGITS-1:0] w_carry;
    logic                  w_load;
    logic                  w_run;
    logic                  w_wrap;
    logic                  w_sat;
    logic                  w_inc;

    assign w_load = T_ld && (T_s == TS_INIT);
    assign w_run  = T_ld && (T_s == TS_TICK);
    assign w_wrap = w_run && (r_pre == c_pre_last);
    // Every digit is 9 only at 99.99.
    assign w_sat  = &w_nine;
    assign w_inc  = w_wrap && !w_sat;

    // The prescaler keeps wrapping while saturated. Hold keeps its partial
    // phase, so a resume does not lose the sub-tick time.
    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_pre <= '0;
        end else if (w_run) begin
            r_pre <= (r_pre == c_pre_last) ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_inc;
        end
    end

    // Carry ripples upward: digit i advances when every lower digit is 9.
    assign w_carry[0] = w_inc;

    generate
        for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_carry
            assign w_carry[i] = w_carry[i-1] && w_nine[i-1];
        end

        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk (clk),
                .rst (rst),
                .clr (w_load),
                .en  (w_carry[i]),
                .q   (w_count[i*DIGIT_W +: DIGIT_W]),
                .co  (w_nine[i])
            );
        end
    endgenerate

    assign T_comp     = (w_count == BCD_MAX);
    assign tick_pulse = r_tick;

`ifdef STOPWATCH_LAP_EN
    logic [15:0] r_lap;
    logic        r_frozen;

    // Load has priority over lap. Lap toggles between capture and live.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lap    <= '0;
            r_frozen <= 1'b0;
        end else if (w_load) begin
            r_frozen <= 1'b0;
        end else if (lap) begin
            if (!r_frozen) begin
                r_lap    <= w_count;
                r_frozen <= 1'b1;
            end else begin
                r_frozen <= 1'b0;
            end
        end
    end

    assign time_bcd = r_frozen ? r_lap : w_count;
`else
    assign time_bcd = w_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_time_counter
// Description : Self-checking bench for stopwatch_time_counter. Two DUTs
//               share the stimulus: DIV=10 (main) and DIV=2 (fast, used to
//               reach 99.99 and the full ripple within a short run). A
//               decimal-arithmetic reference model is compared every cycle.
//               Directed scenarios add literal expectations, and a
//               randomized phase follows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_time_counter;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        T_ld = 1'b1;
    logic        lap  = 1'b0;
    logic [1:0]  T_s  = 2'b10;

    logic [15:0] bcd  [2];
    logic        comp [2];
    logic        tick [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stopwatch_time_counter #(.CLK_HZ(10), .TICK_HZ(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .T_s        (T_s),
        .T_ld       (T_ld),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap),
`endif
        .T_comp     (comp[0]),
        .time_bcd   (bcd[0]),
        .tick_pulse (tick[0])
    );

    stopwatch_time_counter #(.CLK_HZ(2), .TICK_HZ(1)) u_fast (
        .clk        (clk),
        .rst        (rst),
        .T_s        (T_s),
        .T_ld       (T_ld),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap),
`endif
        .T_comp     (comp[1]),
        .time_bcd   (bcd[1]),
        .tick_pulse (tick[1])
    );

    // ---------------- reference model (decimal arithmetic) ----------------
    int m_cnt [2] = '{0, 0};
    int m_pre [2] = '{0, 0};
    int m_lap [2] = '{0, 0};
    bit m_tick[2] = '{1'b0, 1'b0};
    bit m_frz [2] = '{1'b0, 1'b0};

    function automatic int div_of(int k);
        return (k == 0) ? 10 : 2;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k]  <= 0;
                m_pre[k]  <= 0;
                m_lap[k]  <= 0;
                m_tick[k] <= 1'b0;
                m_frz[k]  <= 1'b0;
            end else begin
                m_tick[k] <= 1'b0;
                if (T_ld && T_s == 2'b00) begin
                    m_cnt[k] <= 0;
                    m_pre[k] <= 0;
                end else if (T_ld && T_s == 2'b01) begin
                    if (m_pre[k] == div_of(k) - 1) begin
                        m_pre[k] <= 0;
                        if (m_cnt[k] < 9999) begin
                            m_cnt[k]  <= m_cnt[k] + 1;
                            m_tick[k] <= 1'b1;
                        end
                    end else begin
                        m_pre[k] <= m_pre[k] + 1;
                    end
                end
                if (T_ld && T_s == 2'b00) begin
                    m_frz[k] <= 1'b0;
                end else if (lap) begin
                    if (!m_frz[k]) begin
                        m_lap[k] <= m_cnt[k];
                        m_frz[k] <= 1'b1;
                    end else begin
                        m_frz[k] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model_time_bcd[%0d]", k), {16'h0, bcd[k]},
                      {16'h0, to_bcd(m_frz[k] ? m_lap[k] : m_cnt[k])});
                check($sformatf("model_T_comp[%0d]", k), {31'h0, comp[k]},
                      {31'h0, m_cnt[k] == 9999});
                check($sformatf("model_tick[%0d]", k), {31'h0, tick[k]},
                      {31'h0, m_tick[k]});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed scenarios + random phase ----------------
    initial begin
        int ticks;
        int r;

        cyc(2);
        chk_en = 1'b1;
        check("reset_time",  {16'h0, bcd[0]}, 32'h0);
        check("reset_comp",  {31'h0, comp[0]}, 32'h0);
        check("reset_tick",  {31'h0, tick[0]}, 32'h0);

        // Load then 100 count cycles
        rst = 1'b0; T_s = 2'b00; cyc(1);
        T_s = 2'b01; ticks = 0;
        repeat (100) begin
            cyc(1);
            if (tick[0]) ticks++;
        end
        check("s1_time",  {16'h0, bcd[0]}, 32'h0010);
        check("s1_ticks", ticks, 10);

        // Prescale phase kept across hold
        T_s = 2'b00; cyc(1);
        T_s = 2'b01; cyc(90);
        check("s2_at_9", {16'h0, bcd[0]}, 32'h0009);
        cyc(5);
        T_s = 2'b10; cyc(50);
        check("s2_hold", {16'h0, bcd[0]}, 32'h0009);
        T_s = 2'b01; cyc(4);
        check("s2_before", {16'h0, bcd[0]}, 32'h0009);
        cyc(1);
        check("s2_after", {16'h0, bcd[0]}, 32'h0010);

        // Saturation on the DIV=2 instance
        T_s = 2'b00; cyc(1);
        T_s = 2'b01; cyc(19996);
        check("s3_9998",      {16'h0, bcd[1]}, 32'h9998);
        check("s3_comp_low",  {31'h0, comp[1]}, 32'h0);
        cyc(2);
        check("s3_9999",      {16'h0, bcd[1]}, 32'h9999);
        check("s3_comp_high", {31'h0, comp[1]}, 32'h1);
        ticks = 0;
        repeat (30) begin
            cyc(1);
            if (tick[1]) ticks++;
        end
        check("s3_sat_hold",  {16'h0, bcd[1]}, 32'h9999);
        check("s3_sat_ticks", ticks, 0);

        // d1 carry and full ripple
        T_s = 2'b00; cyc(1);
        T_s = 2'b01; cyc(590);
        check("s4_0059", {16'h0, bcd[0]}, 32'h0059);
        cyc(10);
        check("s4_0060", {16'h0, bcd[0]}, 32'h0060);
        T_s = 2'b00; cyc(1);
        T_s = 2'b01; cyc(1998);
        check("s4_0999", {16'h0, bcd[1]}, 32'h0999);
        cyc(2);
        check("s4_1000", {16'h0, bcd[1]}, 32'h1000);

        // Reset mid-count, then T_ld=0 freezes
        T_s = 2'b00; cyc(1);
        T_s = 2'b01; cyc(420);
        check("s5_0042", {16'h0, bcd[0]}, 32'h0042);
        rst = 1'b1; cyc(1);
        rst = 1'b0;
        check("s5_rst_time", {16'h0, bcd[0]}, 32'h0);
        check("s5_rst_comp", {31'h0, comp[1]}, 32'h0);
        check("s5_rst_tick", {31'h0, tick[0]}, 32'h0);
        T_ld = 1'b0; cyc(30);
        check("s5_ld0_time", {16'h0, bcd[0]}, 32'h0);
        T_ld = 1'b1;

`ifdef STOPWATCH_LAP_EN
        T_s = 2'b00; cyc(1);
        T_s = 2'b01; cyc(200);
        check("lap_0020", {16'h0, bcd[0]}, 32'h0020);
        lap = 1'b1; cyc(1); lap = 1'b0;
        cyc(50);
        check("lap_frozen", {16'h0, bcd[0]}, 32'h0020);
        lap = 1'b1; cyc(1); lap = 1'b0;
        check("lap_release", {16'h0, bcd[0]}, 32'h0025);
        lap = 1'b1; T_s = 2'b00; cyc(1);
        lap = 1'b0; T_s = 2'b01;
        check("lap_load", {16'h0, bcd[0]}, 32'h0000);
        cyc(10);
        check("lap_live", {16'h0, bcd[0]}, 32'h0001);
`endif

        // Randomized phase
        repeat (3000) begin
            rst  = ($urandom_range(0, 199) == 0);
            T_ld = ($urandom_range(0, 9) != 0);
            r    = $urandom_range(0, 9);
            T_s  = (r == 0) ? 2'b00 : (r <= 6) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
            lap  = LAP_EN && ($urandom_range(0, 29) == 0);
            cyc(1);
        end
        rst = 1'b0; lap = 1'b0; T_s = 2'b10;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
